id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, write-back bypass
// into the captured operands, and zero-register handling.
//
// Update priority on every rising CLK edge:
//   RST > flush > stall > load-use bubble > normal load
// A bubble clears the valid bit, every control output, the ALU opcode and the
// destination address. It leaves the data fields alone because nothing
// downstream consumes them once the valid bit and the controls are zero.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            RST,

    // Pipeline control
    input  logic            stall,
    input  logic            flush,

    // Instruction from the decode stage
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rd1,
    input  logic [XLEN-1:0] in_rd2,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic            in_mem_to_reg,
    input  logic            in_alu_src,
    input  logic            in_branch,
    input  logic [3:0]      in_alu_op,

    // Register-file write port of the write-back stage
    input  logic            wb_reg_write,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,

    // Registered instruction for the execute stage
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [AW-1:0]   out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_mem_to_reg,
    output logic            out_alu_src,
    output logic            out_branch,
    output logic [3:0]      out_alu_op,

    // Load-use stall request to the PC and IF/ID stages
    output logic            hazard_stall
);

    localparam logic [AW-1:0] ZERO_REG = '0;

    // Operand values after the zero-register and write-back bypass rules
    logic [XLEN-1:0] fwd_rd1;
    logic [XLEN-1:0] fwd_rd2;

    // Destination of the load in EX matches a source of the instruction in ID
    logic            rd_matches_src;

    // A bubble goes in on a flush, or on a load-use hazard the downstream
    // stage is not already holding.
    logic            insert_bubble;

    // Load-use detection looks only at the EX-side registers and the ID-side
    // source addresses; write-back and stall play no part, so that a held
    // pipeline keeps reporting the hazard until it can be resolved.
    always_comb begin
        rd_matches_src = (out_rd == in_rs1) || (out_rd == in_rs2);
        hazard_stall   = out_valid && out_mem_read && (out_rd != ZERO_REG)
                         && in_valid && rd_matches_src && !flush;
        insert_bubble  = flush || (!stall && hazard_stall);
    end

    // Pick the operand values the execute stage will see: register 0 always
    // reads as zero, otherwise a same-cycle write-back to the source wins
    // over the (stale) register-file read data.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        fwd_rd1 = in_rd1;
        fwd_rd2 = in_rd2;

        if (in_rs1 == ZERO_REG) begin
            fwd_rd1 = '0;
        end else if (wb_reg_write && (wb_rd != ZERO_REG) && (wb_rd == in_rs1)) begin
            fwd_rd1 = wb_data;
        end

        if (in_rs2 == ZERO_REG) begin
            fwd_rd2 = '0;
        end else if (wb_reg_write && (wb_rd != ZERO_REG) && (wb_rd == in_rs2)) begin
            fwd_rd2 = wb_data;
        end
    end

    // Pipeline register: reset, bubble, hold or load, in that priority.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (RST) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_imm        <= '0;
            out_rd1        <= '0;
            out_rd2        <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_alu_src    <= 1'b0;
            out_branch     <= 1'b0;
            out_alu_op     <= '0;
        end else if (insert_bubble) begin
            out_valid      <= 1'b0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_alu_src    <= 1'b0;
            out_branch     <= 1'b0;
            out_alu_op     <= '0;
        end else if (!stall) begin
            // Data fields are always captured; controls only for a real
            // instruction, and a write to register 0 is dropped here so
            // later stages never see it.
            out_valid      <= in_valid;
            out_pc         <= in_pc;
            out_imm        <= in_imm;
            out_rd1        <= fwd_rd1;
            out_rd2        <= fwd_rd2;
            out_rs1        <= in_rs1;
            out_rs2        <= in_rs2;
            out_rd         <= in_rd;
            out_reg_write  <= in_valid && in_reg_write && (in_rd != ZERO_REG);
            out_mem_read   <= in_valid && in_mem_read;
            out_mem_write  <= in_valid && in_mem_write;
            out_mem_to_reg <= in_valid && in_mem_to_reg;
            out_alu_src    <= in_valid && in_alu_src;
            out_branch     <= in_valid && in_branch;
            out_alu_op     <= in_valid ? in_alu_op : 4'h0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural model of what the stage
// must hold is compared against the DUT on every falling edge, and directed
// scenarios add hand-computed literal expectations.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            CLK;
    logic            RST;
    logic            stall, flush;
    logic            in_valid;
    logic [XLEN-1:0] in_pc, in_imm, in_rd1, in_rd2;
    logic [AW-1:0]   in_rs1, in_rs2, in_rd;
    logic            in_reg_write, in_mem_read, in_mem_write;
    logic            in_mem_to_reg, in_alu_src, in_branch;
    logic [3:0]      in_alu_op;
    logic            wb_reg_write;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic [XLEN-1:0] out_pc, out_imm, out_rd1, out_rd2;
    logic [AW-1:0]   out_rs1, out_rs2, out_rd;
    logic            out_reg_write, out_mem_read, out_mem_write;
    logic            out_mem_to_reg, out_alu_src, out_branch;
    logic [3:0]      out_alu_op;
    logic            hazard_stall;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage #(.XLEN(XLEN), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_imm(in_imm),
        .in_rd1(in_rd1), .in_rd2(in_rd2),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_src(in_alu_src), .in_branch(in_branch), .in_alu_op(in_alu_op),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_imm(out_imm),
        .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_alu_src(out_alu_src), .out_branch(out_branch),
        .out_alu_op(out_alu_op), .hazard_stall(hazard_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the instruction the execute stage should see.
    // ------------------------------------------------------------------
    typedef struct {
        logic            valid;
        logic [XLEN-1:0] pc, imm, rd1, rd2;
        logic [AW-1:0]   rs1, rs2, rd;
        logic            rd_known;
        logic            rw, mr, mw, m2r, asrc, br;
        logic [3:0]      op;
    } ex_view_t;

    ex_view_t m;

    // Value an instruction in EX must see for a source register.
    function automatic logic [XLEN-1:0] operand(input logic [AW-1:0] rs, input logic [XLEN-1:0] rf_val);
        if (rs == 0) return '0;
        if (wb_reg_write && wb_rd == rs) return wb_data;
        return rf_val;
    endfunction

    // The load in EX needs its result before the instruction in ID can use it.
    function automatic logic model_hazard();
        return m.valid && m.mr && (m.rd != 0) && in_valid
               && (m.rd == in_rs1 || m.rd == in_rs2) && !flush;
    endfunction

    function automatic ex_view_t empty_slot();
        ex_view_t e;
        e = '{valid: 1'b0, pc: '0, imm: '0, rd1: '0, rd2: '0, rs1: '0, rs2: '0,
              rd: '0, rd_known: 1'b1, rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0,
              asrc: 1'b0, br: 1'b0, op: 4'h0};
        return e;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m = empty_slot();
        end else if (flush || (!stall && model_hazard())) begin
            // Squashed slot: nothing observable except "no instruction".
            m.valid = 1'b0; m.rd = '0; m.rd_known = 1'b1;
            m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.asrc = 0; m.br = 0; m.op = 0;
        end else if (!stall) begin
            m.valid    = in_valid;
            m.pc       = in_pc;
            m.imm      = in_imm;
            m.rd1      = operand(in_rs1, in_rd1);
            m.rd2      = operand(in_rs2, in_rd2);
            m.rs1      = in_rs1;
            m.rs2      = in_rs2;
            m.rd       = in_rd;
            m.rd_known = in_valid;
            m.rw       = in_valid && in_reg_write && in_rd != 0;
            m.mr       = in_valid && in_mem_read;
            m.mw       = in_valid && in_mem_write;
            m.m2r      = in_valid && in_mem_to_reg;
            m.asrc     = in_valid && in_alu_src;
            m.br       = in_valid && in_branch;
            m.op       = in_valid ? in_alu_op : 4'h0;
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge CLK) begin
        check("cmp.valid",     out_valid,      m.valid);
        check("cmp.reg_write", out_reg_write,  m.rw);
        check("cmp.mem_read",  out_mem_read,   m.mr);
        check("cmp.mem_write", out_mem_write,  m.mw);
        check("cmp.mem_to_reg",out_mem_to_reg, m.m2r);
        check("cmp.alu_src",   out_alu_src,    m.asrc);
        check("cmp.branch",    out_branch,     m.br);
        check("cmp.alu_op",    out_alu_op,     m.op);
        check("cmp.hazard",    hazard_stall,   model_hazard());
        if (m.rd_known) check("cmp.rd", out_rd, m.rd);
        if (m.valid) begin
            check("cmp.pc",  out_pc,  m.pc);
            check("cmp.imm", out_imm, m.imm);
            check("cmp.rd1", out_rd1, m.rd1);
            check("cmp.rd2", out_rd2, m.rd2);
            check("cmp.rs1", out_rs1, m.rs1);
            check("cmp.rs2", out_rs2, m.rs2);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [XLEN-1:0] pc,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [AW-1:0] rd, input logic [XLEN-1:0] r1,
                             input logic [XLEN-1:0] r2, input logic [3:0] op,
                             input logic rw, input logic mr, input logic mw);
        in_valid = v; in_pc = pc; in_imm = pc ^ 32'h0000_0F0F;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd1 = r1; in_rd2 = r2;
        in_alu_op = op; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
        in_mem_to_reg = mr; in_alu_src = mr | mw; in_branch = 1'b0;
    endtask

    task automatic set_wb(input logic we, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        wb_reg_write = we; wb_rd = rd; wb_data = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, out_valid, 1'b0);
        check({tag, ".ctrl"}, {out_reg_write, out_mem_read, out_mem_write,
                               out_mem_to_reg, out_alu_src, out_branch}, 6'h0);
        check({tag, ".alu_op"}, out_alu_op, 4'h0);
        check({tag, ".pc"}, out_pc, 32'h0);
        check({tag, ".rd1"}, out_rd1, 32'h0);
        check({tag, ".rd"}, out_rd, 5'h0);
    endtask

    // Watchdog: the run is a fixed sequence and must end long before this.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(1'b0, '0, '0, '0, '0, '0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        set_wb(1'b0, '0, '0);
        #2;
        check_all_zero("reset");
        cycle(); cycle();
        RST = 1'b0;

        // Plain load of an ALU instruction.
        set_instr(1'b1, 32'h100, 5'd3, 5'd4, 5'd1, 32'h11, 32'h22, 4'h2, 1'b1, 1'b0, 1'b0);
        cycle();
        check("load.valid",  out_valid,  1'b1);
        check("load.rd1",    out_rd1,    32'h11);
        check("load.alu_op", out_alu_op, 4'h2);

        // Load-use: lw x5 in EX, add using rs2=x5 in ID.
        set_instr(1'b1, 32'h104, 5'd2, 5'd0, 5'd5, 32'h40, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle();
        set_instr(1'b1, 32'h108, 5'd4, 5'd5, 5'd6, 32'h7, 32'h9, 4'h1, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu.hazard_on", hazard_stall, 1'b1);
        cycle();
        check("lu.bubble_valid", out_valid, 1'b0);
        check("lu.bubble_rd",    out_rd,    5'd0);
        #1;
        check("lu.hazard_off", hazard_stall, 1'b0);
        cycle();
        check("lu.add_valid", out_valid, 1'b1);
        check("lu.add_rd",    out_rd,    5'd6);
        check("lu.add_pc",    out_pc,    32'h108);

        // Write-back bypass and zero register.
        set_wb(1'b1, 5'd7, 32'hDEADBEEF);
        set_instr(1'b1, 32'h10C, 5'd7, 5'd8, 5'd9, 32'h0, 32'h33, 4'h3, 1'b1, 1'b0, 1'b0);
        cycle();
        check("byp.rd1", out_rd1, 32'hDEADBEEF);
        check("byp.rd2", out_rd2, 32'h33);
        set_wb(1'b1, 5'd0, 32'hDEADBEEF);
        set_instr(1'b1, 32'h110, 5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 4'h3, 1'b1, 1'b0, 1'b0);
        cycle();
        check("zero.rd1", out_rd1, 32'h0);
        check("zero.rd2", out_rd2, 32'h0);
        set_wb(1'b1, 5'd8, 32'hCAFE0001);
        set_instr(1'b1, 32'h114, 5'd1, 5'd8, 5'd9, 32'h1, 32'h2, 4'h3, 1'b1, 1'b0, 1'b0);
        cycle();
        check("byp.rd2_fwd", out_rd2, 32'hCAFE0001);
        check("byp.rd1_rf",  out_rd1, 32'h1);
        set_wb(1'b0, '0, '0);

        // Write to x0 is dropped; invalid instruction clears controls.
        set_instr(1'b1, 32'h118, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 4'h5, 1'b1, 1'b0, 1'b0);
        cycle();
        check("x0.reg_write", out_reg_write, 1'b0);
        check("x0.valid",     out_valid,     1'b1);
        set_instr(1'b0, 32'h11C, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 4'h7, 1'b1, 1'b1, 1'b1);
        cycle();
        check("inv.valid",  out_valid,  1'b0);
        check("inv.ctrl",   {out_reg_write, out_mem_read, out_mem_write}, 3'b000);
        check("inv.alu_op", out_alu_op, 4'h0);

        // Stall holds everything, even with a dependent load-use pair.
        set_instr(1'b1, 32'h120, 5'd1, 5'd2, 5'd10, 32'h1, 32'h2, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle();
        stall = 1'b1;
        set_instr(1'b1, 32'h124, 5'd10, 5'd3, 5'd11, 32'h5, 32'h6, 4'h9, 1'b1, 1'b0, 1'b1);
        #1;
        check("stall.hazard", hazard_stall, 1'b1);
        cycle();
        check("stall.pc",       out_pc,       32'h120);
        check("stall.valid",    out_valid,    1'b1);
        check("stall.mem_read", out_mem_read, 1'b1);

        // Flush wins over stall and masks the hazard.
        flush = 1'b1;
        #1;
        check("flush.hazard", hazard_stall, 1'b0);
        cycle();
        check("flush.valid",     out_valid,     1'b0);
        check("flush.reg_write", out_reg_write, 1'b0);
        check("flush.mem_write", out_mem_write, 1'b0);
        check("flush.rd",        out_rd,        5'd0);
        flush = 1'b0; stall = 1'b0;
        cycle();
        check("after_flush.pc", out_pc, 32'h124);

        // Asynchronous reset between edges, held across an edge.
        set_instr(1'b1, 32'h128, 5'd4, 5'd5, 5'd12, 32'hA, 32'hB, 4'h6, 1'b1, 1'b1, 1'b0);
        cycle();
        check("pre_rst.valid", out_valid, 1'b1);
        #1 RST = 1'b1;
        #1;
        check_all_zero("async_rst");
        check("async_rst.hazard", hazard_stall, 1'b0);
        cycle();
        check_all_zero("rst_hold");
        RST = 1'b0;
        cycle();
        check("post_rst.valid", out_valid, 1'b1);
        check("post_rst.pc",    out_pc,    32'h128);

        // Pseudo-random traffic over a small register window, checked by
        // the compare process against the model.
        for (int i = 0; i < 60; i++) begin
            set_instr(1'($urandom_range(0, 3) != 0), 32'h200 + 32'(i * 4),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), $urandom, $urandom,
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            in_branch = 1'($urandom_range(0, 1));
            set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            cycle();
        end
        stall = 1'b0; flush = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
